clock_step_ctrl: RTL and testbench

- Control stage directly upstream of clockswitch; runs on the free-running oscillator clock.
- Debounces the front-panel mode switch and single-step button.
- Drives clockswitch's `sel` input and generates the manual step clock that feeds clockswitch's `clk1` input.
- Forces step mode while the CPU asserts `halt`, so the free-running clock never reaches the core during halt.

---
 rtl/clock_step_pkg.sv | 17 +
 rtl/sync_debounce.sv | 40 ++++
 rtl/clock_step_ctrl.sv | 106 ++++++++++
 tb/tb_clock_step_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_step_pkg.sv
// Shared types and defaults for the clock step control stage.
package clock_step_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RELEASE = 2'd2
    } step_state_t;

    localparam logic SEL_FREE = 1'b0;
    localparam logic SEL_STEP = 1'b1;

    localparam int DEFAULT_DEBOUNCE_CYCLES  = 16;
    localparam int DEFAULT_STEP_HIGH_CYCLES = 4;
    localparam int DEFAULT_CNT_W            = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// follows the synchronized input only after DEBOUNCE_CYCLES differing cycles.
module sync_debounce
    import clock_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // NOTE: all state here is sequential, so only non-blocking assignments are
    // used; blocking ones would let the second sync flop see this cycle's raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            debounced <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == debounced) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                debounced <= sync_q[1];
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_step_ctrl.sv
// Front-panel run/step control feeding clockswitch: debounced mode and step
// inputs, registered sel and a flop-driven step clock. Optional STEP_COUNT_EN.
module clock_step_ctrl
    import clock_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int STEP_HIGH_CYCLES = DEFAULT_STEP_HIGH_CYCLES,
    parameter int CNT_W            = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic mode_sw_raw,
    input  logic step_btn_raw,
    input  logic halt,
    output logic sel,
    output logic step_clk,
    output logic manual_mode
`ifdef STEP_COUNT_EN
    , output logic [CNT_W-1:0] step_count
`endif
);

    localparam int PW = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(STEP_HIGH_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || STEP_HIGH_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("clock_step_ctrl: illegal parameter value");
    end

    step_state_t   state_q;
    logic [PW-1:0] pulse_cnt_q;
    logic          btn_db;
    logic          btn_prev_q;
    logic          press;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk       (clk),
        .rst       (rst),
        .raw       (mode_sw_raw),
        .debounced (manual_mode)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk       (clk),
        .rst       (rst),
        .raw       (step_btn_raw),
        .debounced (btn_db)
    );

    assign press = btn_db & ~btn_prev_q;

    // NOTE: memories aside, every control flop here is reset, because a stale
    // step_clk or sel after reset would glitch the clock mux downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            step_clk    <= 1'b0;
            sel         <= SEL_FREE;
            btn_prev_q  <= 1'b0;
`ifdef STEP_COUNT_EN
            step_count  <= '0;
`endif
        end else begin
            btn_prev_q <= btn_db;

            // Leaving step mode waits for step_clk low so clk1 is never cut mid-pulse.
            if (manual_mode | halt) begin
                sel <= SEL_STEP;
            end else if (!step_clk) begin
                sel <= SEL_FREE;
            end

            case (state_q)
                IDLE: begin
                    if (press && sel == SEL_STEP && !halt) begin
                        state_q     <= PULSE;
                        step_clk    <= 1'b1;
                        pulse_cnt_q <= '0;
`ifdef STEP_COUNT_EN
                        step_count  <= step_count + 1'b1;
`endif
                    end
                end
                PULSE: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_q  <= RELEASE;
                        step_clk <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!btn_db) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    step_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed plus randomized bench for clock_step_ctrl against a cycle-level
// behavioural model (DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3).
module tb_clock_step_ctrl;

    localparam int DB = 4;
    localparam int SH = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_sw_raw = 1'b0;
    logic step_btn_raw = 1'b0;
    logic halt = 1'b0;
    logic sel, step_clk, manual_mode;
`ifdef STEP_COUNT_EN
    logic [CW-1:0] step_count;
`endif

    always #5 clk = ~clk;

    clock_step_ctrl #(
        .DEBOUNCE_CYCLES  (DB),
        .STEP_HIGH_CYCLES (SH),
        .CNT_W            (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_sw_raw  (mode_sw_raw),
        .step_btn_raw (step_btn_raw),
        .halt         (halt),
        .sel          (sel),
        .step_clk     (step_clk),
        .manual_mode  (manual_mode)
`ifdef STEP_COUNT_EN
        , .step_count (step_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Observed-waveform statistics for directed checks.
    int pulse_edges = 0;
    int high_cycles = 0;
    bit last_step   = 1'b0;

    // Behavioural reference: raw inputs seen through a two-sample delay, a
    // level that flips after DB consecutive disagreeing samples, a pulse as a
    // countdown of remaining high cycles, and a "must release first" flag.
    bit m_mode_d1, m_mode_d2, m_btn_d1, m_btn_d2;
    bit m_mode_db, m_btn_db, m_btn_prev, m_sel, m_await;
    int m_mode_run, m_btn_run, m_pulse_left, m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit mode_sync, btn_sync, mode_db_o, btn_db_o, prev_o, sel_o, pulsing_o;
        if (rst) begin
            m_mode_d1 = 0; m_mode_d2 = 0; m_btn_d1 = 0; m_btn_d2 = 0;
            m_mode_db = 0; m_btn_db = 0; m_btn_prev = 0; m_sel = 0; m_await = 0;
            m_mode_run = 0; m_btn_run = 0; m_pulse_left = 0; m_count = 0;
        end else begin
            mode_sync = m_mode_d2;
            btn_sync  = m_btn_d2;
            mode_db_o = m_mode_db;
            btn_db_o  = m_btn_db;
            prev_o    = m_btn_prev;
            sel_o     = m_sel;
            pulsing_o = (m_pulse_left > 0);

            m_mode_d2 = m_mode_d1; m_mode_d1 = mode_sw_raw;
            m_btn_d2  = m_btn_d1;  m_btn_d1  = step_btn_raw;

            if (mode_sync != m_mode_db) begin
                m_mode_run++;
                if (m_mode_run == DB) begin m_mode_db = mode_sync; m_mode_run = 0; end
            end else m_mode_run = 0;
            if (btn_sync != m_btn_db) begin
                m_btn_run++;
                if (m_btn_run == DB) begin m_btn_db = btn_sync; m_btn_run = 0; end
            end else m_btn_run = 0;

            if (mode_db_o || halt) m_sel = 1;
            else if (!pulsing_o)   m_sel = 0;

            if (m_pulse_left > 0) begin
                m_pulse_left--;
                if (m_pulse_left == 0) m_await = 1;
            end else if (m_await) begin
                if (!btn_db_o) m_await = 0;
            end else if (btn_db_o && !prev_o && sel_o && !halt) begin
                m_pulse_left = SH;
                m_count = (m_count + 1) % (1 << CW);
            end
            m_btn_prev = btn_db_o;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (step_clk && !last_step) pulse_edges++;
        if (step_clk) high_cycles++;
        last_step = step_clk;
        check("sel", 32'(sel), 32'(m_sel));
        check("step_clk", 32'(step_clk), 32'(m_pulse_left > 0));
        check("manual_mode", 32'(manual_mode), 32'(m_mode_db));
`ifdef STEP_COUNT_EN
        check("step_count", 32'(step_count), 32'(m_count));
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_step_high(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (step_clk) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        bit seen;

        // Reset with raw inputs toggling.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode_sw_raw  = ~mode_sw_raw;
            step_btn_raw = ~step_btn_raw;
            tick();
        end
        rst = 1'b0; mode_sw_raw = 1'b0; step_btn_raw = 1'b0;
        tick();
        check("post_reset_sel", 32'(sel), 32'd0);
        check("post_reset_step_clk", 32'(step_clk), 32'd0);
        check("post_reset_manual", 32'(manual_mode), 32'd0);

        // Mode debounce latency: manual_mode after 6 cycles, sel one later.
        mode_sw_raw = 1'b1;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (manual_mode) n = i;
        end
        check("mode_latency", 32'(n), 32'd6);
        tick();
        check("sel_after_mode", 32'(sel), 32'd1);

        // Two-cycle glitch must be filtered out.
        mode_sw_raw = 1'b0; ticks(2);
        mode_sw_raw = 1'b1; ticks(10);
        check("glitch_manual", 32'(manual_mode), 32'd1);

        // Bouncy press then long hold: one pulse, SH cycles wide.
        pulse_edges = 0; high_cycles = 0;
        step_btn_raw = 1'b1; tick();
        step_btn_raw = 1'b0; tick();
        step_btn_raw = 1'b1; tick();
        ticks(20);
        check("single_pulse_count", 32'(pulse_edges), 32'd1);
        check("single_pulse_width", 32'(high_cycles), 32'(SH));
        step_btn_raw = 1'b0; ticks(10);
        step_btn_raw = 1'b1; ticks(15);
        check("second_pulse_count", 32'(pulse_edges), 32'd2);
        check("second_pulse_width", 32'(high_cycles), 32'(2 * SH));
        step_btn_raw = 1'b0; ticks(10);
`ifdef STEP_COUNT_EN
        check("count_two", 32'(step_count), 32'd2);
`endif

        // Free run: presses ignored.
        mode_sw_raw = 1'b0; ticks(10);
        check("free_sel", 32'(sel), 32'd0);
        pulse_edges = 0;
        step_btn_raw = 1'b1; ticks(10);
        step_btn_raw = 1'b0; ticks(10);
        check("free_no_pulse", 32'(pulse_edges), 32'd0);
`ifdef STEP_COUNT_EN
        check("free_count", 32'(step_count), 32'd2);
`endif

        // Halt forces step select and blocks presses.
        halt = 1'b1; tick();
        check("halt_sel", 32'(sel), 32'd1);
        step_btn_raw = 1'b1; ticks(10);
        step_btn_raw = 1'b0; ticks(10);
        check("halt_no_pulse", 32'(pulse_edges), 32'd0);
        halt = 1'b0; tick();
        check("unhalt_sel", 32'(sel), 32'd0);

        // Halt rising on the first pulse cycle leaves the pulse full width.
        mode_sw_raw = 1'b1; ticks(10);
        pulse_edges = 0; high_cycles = 0;
        step_btn_raw = 1'b1;
        wait_step_high("halt_pulse_start");
        halt = 1'b1; ticks(6);
        check("halt_pulse_width", 32'(high_cycles), 32'(SH));
        check("halt_pulse_count", 32'(pulse_edges), 32'd1);
        step_btn_raw = 1'b0; ticks(10);
        halt = 1'b0; ticks(2);

        // Mode drops to free run while pulsing: sel held until step_clk low.
        step_btn_raw = 1'b1; ticks(2);
        mode_sw_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step_clk) begin
                seen = 1'b1;
                check("sel_held_in_pulse", 32'(sel), 32'd1);
            end else if (seen) begin
                break;
            end
        end
        check("midpulse_seen", 32'(seen), 32'd1);
        check("midpulse_manual_low", 32'(manual_mode), 32'd0);
        tick();
        check("sel_after_pulse", 32'(sel), 32'd0);
        step_btn_raw = 1'b0; ticks(10);

        // Reset during a pulse kills step_clk on the next edge.
        mode_sw_raw = 1'b1; ticks(10);
        step_btn_raw = 1'b1;
        wait_step_high("reset_pulse_start");
        rst = 1'b1; tick();
        check("reset_step_clk", 32'(step_clk), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        rst = 1'b0; step_btn_raw = 1'b0; mode_sw_raw = 1'b0;
        ticks(5);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) mode_sw_raw  = ~mode_sw_raw;
            if ($urandom_range(11) == 0) step_btn_raw = ~step_btn_raw;
            if ($urandom_range(59) == 0) halt         = ~halt;
            rst = ($urandom_range(399) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
